// File: rtl/y86_pkg.sv
// Shared writeback types for the sequential Y86-64 core: register IDs,
// word width and the E/M result entry carried from execute to register_file.
package y86_pkg;

   localparam logic [3:0] REG_NONE = 4'hF;
   localparam int         NUM_REGS = 15;
   localparam int         WORD_W   = 64;

   typedef struct packed {
      logic [3:0]        dstE;
      logic [WORD_W-1:0] valE;
      logic [3:0]        dstM;
      logic [WORD_W-1:0] valM;
   } wb_entry_t;

   localparam int ENTRY_W = $bits(wb_entry_t);

   localparam wb_entry_t WB_IDLE = '{dstE: REG_NONE, valE: '0, dstM: REG_NONE, valM: '0};

   // One-hot register bit for an ID; REG_NONE maps to no bit.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] id);
      logic [NUM_REGS-1:0] m;
      m = '0;
      if (id != REG_NONE) m[id] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with per-slot valid flags so the owner can inspect
// every queued entry (used for the pending-write mask).
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push_i,
   input  logic [W-1:0]                  wdata_i,
   input  logic                          pop_i,
   output logic [W-1:0]                  head_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic [DEPTH-1:0][W-1:0]       slot_o,
   output logic [DEPTH-1:0]              slot_valid_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  mem_q   [DEPTH];
   logic          valid_q [DEPTH];
   logic          do_push, do_pop;

   // The FIFO protects itself: no pop when empty, no push when full.
   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         always_ff @(posedge clock) begin
            if (reset) begin
               valid_q[gi] <= 1'b0;
            end else if (do_push && wr_ptr_q == AW'(gi)) begin
               valid_q[gi] <= 1'b1;
            end else if (do_pop && rd_ptr_q == AW'(gi)) begin
               valid_q[gi] <= 1'b0;
            end
         end

         always_ff @(posedge clock) begin
            if (do_push && wr_ptr_q == AW'(gi)) mem_q[gi] <= wdata_i;
         end

         assign slot_o[gi]       = mem_q[gi];
         assign slot_valid_o[gi] = valid_q[gi];
      end
   endgenerate

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/regfile_write_queue.sv
// Write-side front end for register_file: buffers E/M results, drops bubbles,
// drains one entry per cycle through a registered port stage, exposes pending mask.
module regfile_write_queue
   import y86_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_dstE,
   input  logic [WORD_W-1:0]      in_valE,
   input  logic [3:0]             in_dstM,
   input  logic [WORD_W-1:0]      in_valM,
   input  logic                   hold,
   output logic [3:0]             dstE,
   output logic [WORD_W-1:0]      valE,
   output logic [3:0]             dstM,
   output logic [WORD_W-1:0]      valM,
   output logic [NUM_REGS-1:0]    pending_mask,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t                       in_entry, head, out_q, out_d;
   logic [DEPTH-1:0][ENTRY_W-1:0]   slots;
   logic [DEPTH-1:0]                slot_valid;
   logic [CW-1:0]                   fifo_count;
   logic                            accept, is_bubble, push, pop;
   logic [NUM_REGS-1:0]             mask;

   assign in_entry  = '{dstE: in_dstE, valE: in_valE, dstM: in_dstM, valM: in_valM};
   assign is_bubble = (in_dstE == REG_NONE) && (in_dstM == REG_NONE);
   assign in_ready  = fifo_count < CW'(DEPTH);
   assign accept    = in_valid && in_ready;
   // Bubbles complete the handshake but never occupy a slot.
   assign push      = accept && !is_bubble;
   assign pop       = !hold && (fifo_count != '0);

   wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_i       (push),
      .wdata_i      (in_entry),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (fifo_count),
      .slot_o       (slots),
      .slot_valid_o (slot_valid)
   );

   assign out_d = pop ? head : WB_IDLE;

   always_ff @(posedge clock) begin
      if (reset) out_q <= WB_IDLE;
      else       out_q <= out_d;
   end

   // Registers still owed a write: everything queued plus what sits on the ports.
   always_comb begin
      wb_entry_t e;
      mask = reg_onehot(out_q.dstE) | reg_onehot(out_q.dstM);
      for (int i = 0; i < DEPTH; i++) begin
         e = wb_entry_t'(slots[i]);
         if (slot_valid[i]) mask = mask | reg_onehot(e.dstE) | reg_onehot(e.dstM);
      end
   end

   assign pending_mask = mask;
   assign count        = fifo_count;
   assign dstE         = out_q.dstE;
   assign valE         = out_q.valE;
   assign dstM         = out_q.dstM;
   assign valM         = out_q.valM;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed and random stimulus for regfile_write_queue, checked cycle by cycle
// against a queue-based behavioural model of the write queue.
module tb_regfile_write_queue;
   import y86_pkg::*;

   localparam int DEPTH = 4;

   logic              clock, reset, in_valid, in_ready, hold;
   logic [3:0]        in_dstE, in_dstM, dstE, dstM;
   logic [63:0]       in_valE, in_valM, valE, valM;
   logic [14:0]       pending_mask;
   logic [2:0]        count;

   int n_cmp = 0;
   int n_err = 0;

   wb_entry_t mq[$];
   wb_entry_t mout;

   regfile_write_queue #(.DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_dstE      (in_dstE),
      .in_valE      (in_valE),
      .in_dstM      (in_dstM),
      .in_valM      (in_valM),
      .hold         (hold),
      .dstE         (dstE),
      .valE         (valE),
      .dstM         (dstM),
      .valM         (valM),
      .pending_mask (pending_mask),
      .count        (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic wb_entry_t mk(input logic [3:0] de, input logic [63:0] ve,
                                    input logic [3:0] dm, input logic [63:0] vm);
      wb_entry_t e;
      e.dstE = de; e.valE = ve; e.dstM = dm; e.valM = vm;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] bits_of(input wb_entry_t e);
      logic [14:0] m;
      m = '0;
      if (e.dstE != 4'hF) m[e.dstE] = 1'b1;
      if (e.dstM != 4'hF) m[e.dstM] = 1'b1;
      return m;
   endfunction

   task automatic check_all();
      logic [14:0] m;
      m = bits_of(mout);
      foreach (mq[i]) m = m | bits_of(mq[i]);
      chk("dstE", 64'(dstE), 64'(mout.dstE));
      chk("valE", valE, mout.valE);
      chk("dstM", 64'(dstM), 64'(mout.dstM));
      chk("valM", valM, mout.valM);
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("pending_mask", 64'(pending_mask), 64'(m));
   endtask

   // Apply one cycle of inputs, advance the model over the edge, then compare.
   task automatic cyc(input logic v, input wb_entry_t e, input logic h, input logic r);
      logic rdy;
      in_valid = v; hold = h; reset = r;
      in_dstE = e.dstE; in_valE = e.valE; in_dstM = e.dstM; in_valM = e.valM;
      if (r) begin
         mq.delete();
         mout = WB_IDLE;
      end else begin
         rdy = mq.size() < DEPTH;
         if (!h && mq.size() > 0) mout = mq.pop_front();
         else                     mout = WB_IDLE;
         if (v && rdy && !(e.dstE == 4'hF && e.dstM == 4'hF)) mq.push_back(e);
      end
      @(posedge clock);
      #1;
      check_all();
      $display("cycle v=%0b h=%0b r=%0b in=(%0h,%0h,%0h,%0h) -> out=(%0h,%0h,%0h,%0h) cnt=%0d mask=%04h",
               v, h, r, e.dstE, e.valE, e.dstM, e.valM, dstE, valE, dstM, valM, count, pending_mask);
   endtask

   wb_entry_t bub;

   initial begin
      bub = mk(4'hF, 64'd0, 4'hF, 64'd0);
      mout = WB_IDLE;
      in_valid = 0; hold = 0; reset = 1;
      in_dstE = 4'hF; in_valE = 0; in_dstM = 4'hF; in_valM = 0;
      cyc(0, bub, 0, 1);
      cyc(0, bub, 0, 1);
      chk("reset_mask", 64'(pending_mask), 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd1);

      // Single entry: ports one edge after accept, mask for two cycles.
      cyc(1, mk(4'd2, 64'd65535, 4'hF, 64'd0), 0, 0);
      chk("single_mask_a", 64'(pending_mask), 64'h0004);
      cyc(0, bub, 0, 0);
      chk("single_port", 64'(valE), 64'd65535);
      chk("single_mask_b", 64'(pending_mask), 64'h0004);
      cyc(0, bub, 0, 0);
      chk("single_mask_c", 64'(pending_mask), 64'h0000);

      // Fill under hold, fifth offer refused, then release.
      for (int i = 0; i < 5; i++) cyc(1, mk(4'(i), 64'd255, 4'hF, 64'd0), 1, 0);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_mask", 64'(pending_mask), 64'h000F);
      for (int i = 0; i < 5; i++) cyc(0, bub, 0, 0);

      // Back-to-back stream.
      for (int i = 0; i < 8; i++) cyc(1, mk(4'(i + 5), 64'(i * 3 + 7), 4'hF, 64'd0), 0, 0);
      cyc(0, bub, 0, 0);
      cyc(0, bub, 0, 0);

      // Bubble and same-register E/M.
      cyc(1, bub, 0, 0);
      chk("bubble_count", 64'(count), 64'd0);
      cyc(1, mk(4'd4, 64'd1, 4'd4, 64'd2), 0, 0);
      cyc(0, bub, 0, 0);
      chk("conflict_mask", 64'(pending_mask), 64'h0010);
      cyc(0, bub, 0, 0);

      // Reset with queued entries.
      for (int i = 0; i < 3; i++) cyc(1, mk(4'(i + 8), 64'(100 + i), 4'd1, 64'd9), 1, 0);
      cyc(0, bub, 1, 1);
      chk("rst_mid_count", 64'(count), 64'd0);
      cyc(0, bub, 0, 0);
      cyc(0, bub, 0, 0);

      // Random traffic with occasional hold and reset.
      for (int n = 0; n < 400; n++) begin
         logic [3:0] de, dm;
         de = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         dm = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         cyc($urandom_range(0, 3) != 0,
             mk(de, {$urandom, $urandom}, dm, {$urandom, $urandom}),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 99) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
